// File: rtl/axi_wr_arbiter_if.sv
// rtl/axi_wr_arbiter_if.sv - Upstream (S_*) and downstream (M_*) AXI4 write-channel bundle for axi_wr_arbiter
// LEN_ERR exists only when AXI_WR_ARB_LENCHK_EN is defined.
interface axi_wr_arbiter_if #(
  parameter int ID_W     = 4,
  parameter int DATA_LEN = 32
) ();
  localparam int STRB_W = DATA_LEN / 8;

  // Upstream, two masters packed side by side (master i in slice i)
  logic [1:0]            S_AWVALID;
  logic [1:0]            S_AWREADY;
  logic [63:0]           S_AWADDR;
  logic [15:0]           S_AWLEN;
  logic [5:0]            S_AWSIZE;
  logic [3:0]            S_AWBURST;
  logic [2*ID_W-1:0]     S_AWID;
  logic [1:0]            S_WVALID;
  logic [1:0]            S_WREADY;
  logic [1:0]            S_WLAST;
  logic [2*DATA_LEN-1:0] S_WDATA;
  logic [2*STRB_W-1:0]   S_WSTRB;
  logic [1:0]            S_BVALID;
  logic [1:0]            S_BREADY;
  logic [1:0]            S_BRESP;
  logic [ID_W-1:0]       S_BID;

  // Downstream single port; the ID carries one extra routing bit
  logic                  M_AWVALID;
  logic                  M_AWREADY;
  logic [31:0]           M_AWADDR;
  logic [7:0]            M_AWLEN;
  logic [2:0]            M_AWSIZE;
  logic [1:0]            M_AWBURST;
  logic [ID_W:0]         M_AWID;
  logic                  M_WVALID;
  logic                  M_WREADY;
  logic                  M_WLAST;
  logic [DATA_LEN-1:0]   M_WDATA;
  logic [STRB_W-1:0]     M_WSTRB;
  logic                  M_BVALID;
  logic                  M_BREADY;
  logic [1:0]            M_BRESP;
  logic [ID_W:0]         M_BID;
`ifdef AXI_WR_ARB_LENCHK_EN
  logic                  LEN_ERR;
`endif

  // master: the arbiter itself (it masters the downstream port)
  modport master (
    input  S_AWVALID, S_AWADDR, S_AWLEN, S_AWSIZE, S_AWBURST, S_AWID,
    input  S_WVALID, S_WLAST, S_WDATA, S_WSTRB, S_BREADY,
    input  M_AWREADY, M_WREADY, M_BVALID, M_BRESP, M_BID,
    output S_AWREADY, S_WREADY, S_BVALID, S_BRESP, S_BID,
    output M_AWVALID, M_AWADDR, M_AWLEN, M_AWSIZE, M_AWBURST, M_AWID,
    output M_WVALID, M_WLAST, M_WDATA, M_WSTRB, M_BREADY
`ifdef AXI_WR_ARB_LENCHK_EN
    , output LEN_ERR
`endif
  );

  // slave: the surrounding upstream masters and downstream slave
  modport slave (
    output S_AWVALID, S_AWADDR, S_AWLEN, S_AWSIZE, S_AWBURST, S_AWID,
    output S_WVALID, S_WLAST, S_WDATA, S_WSTRB, S_BREADY,
    output M_AWREADY, M_WREADY, M_BVALID, M_BRESP, M_BID,
    input  S_AWREADY, S_WREADY, S_BVALID, S_BRESP, S_BID,
    input  M_AWVALID, M_AWADDR, M_AWLEN, M_AWSIZE, M_AWBURST, M_AWID,
    input  M_WVALID, M_WLAST, M_WDATA, M_WSTRB, M_BREADY
`ifdef AXI_WR_ARB_LENCHK_EN
    , input LEN_ERR
`endif
  );
endinterface

// File: rtl/axi_wr_arbiter.sv
// rtl/axi_wr_arbiter.sv - Two-master round-robin AXI4 write arbiter; optional AWLEN-based WLAST under AXI_WR_ARB_LENCHK_EN
module axi_wr_arbiter #(
  parameter int ID_W      = 4,
  parameter int DATA_LEN  = 32,
  parameter int MAX_OUTST = 8
) (
  input logic              ACLK,
  input logic              ARESET,
  axi_wr_arbiter_if.master bus
);
  localparam int         STRB_W  = DATA_LEN / 8;
  localparam logic [7:0] MAX_CNT = 8'(MAX_OUTST);
  localparam logic [0:0] IDLE    = 1'b0;
  localparam logic [0:0] ACTIVE  = 1'b1;

  logic [0:0]    state;
  logic          gnt, rr_ptr, aw_done, w_done, aw_valid;
  logic [7:0]    outst_cnt;
  logic [31:0]   aw_addr;
  logic [7:0]    aw_len;
  logic [2:0]    aw_size;
  logic [1:0]    aw_burst;
  logic [ID_W:0] aw_id;
  logic          sel, grant_ok, w_open, w_last, w_hs, aw_hs, b_hs, b_sel;

  // A tie goes to rr_ptr; otherwise the lone requester wins
  assign sel      = (bus.S_AWVALID == 2'b11) ? rr_ptr : bus.S_AWVALID[1];
  assign grant_ok = ~ARESET & (state == IDLE) & (outst_cnt < MAX_CNT) & (|bus.S_AWVALID);
  assign bus.S_AWREADY = {grant_ok & sel, grant_ok & ~sel};

  assign bus.M_AWVALID = aw_valid;
  assign bus.M_AWADDR  = aw_addr;
  assign bus.M_AWLEN   = aw_len;
  assign bus.M_AWSIZE  = aw_size;
  assign bus.M_AWBURST = aw_burst;
  assign bus.M_AWID    = aw_id;
  assign aw_hs         = aw_valid & bus.M_AWREADY;

  // W is a pass-through for the granted master until its last beat
  assign w_open       = ~ARESET & (state == ACTIVE) & ~w_done;
  assign bus.M_WVALID = w_open & bus.S_WVALID[gnt];
  assign bus.S_WREADY = {w_open & bus.M_WREADY & gnt, w_open & bus.M_WREADY & ~gnt};
  assign bus.M_WDATA  = gnt ? bus.S_WDATA[2*DATA_LEN-1:DATA_LEN] : bus.S_WDATA[DATA_LEN-1:0];
  assign bus.M_WSTRB  = gnt ? bus.S_WSTRB[2*STRB_W-1:STRB_W] : bus.S_WSTRB[STRB_W-1:0];
  assign bus.M_WLAST  = w_last;
  assign w_hs         = bus.M_WVALID & bus.M_WREADY;

`ifdef AXI_WR_ARB_LENCHK_EN
  logic [7:0] beat_cnt;
  logic       len_err;
  assign w_last      = (beat_cnt == aw_len);
  assign bus.LEN_ERR = len_err;

  // Count accepted beats of the current burst and flag a master whose WLAST disagrees with AWLEN
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      beat_cnt <= 8'd0;
      len_err  <= 1'b0;
    end else begin
      len_err <= w_hs & (bus.S_WLAST[gnt] != w_last);
      if (grant_ok) beat_cnt <= 8'd0;
      else if (w_hs) beat_cnt <= beat_cnt + 8'd1;
    end
  end
`else
  assign w_last = bus.S_WLAST[gnt];
`endif

  // B is steered by the routing bit on top of the downstream ID, regardless of FSM state
  assign b_sel        = bus.M_BID[ID_W];
  assign bus.S_BVALID = {~ARESET & bus.M_BVALID & b_sel, ~ARESET & bus.M_BVALID & ~b_sel};
  assign bus.M_BREADY = ~ARESET & bus.S_BREADY[b_sel];
  assign bus.S_BID    = bus.M_BID[ID_W-1:0];
  assign bus.S_BRESP  = bus.M_BRESP;
  assign b_hs         = bus.M_BVALID & bus.M_BREADY;

  // Grant in IDLE, then hold the burst in ACTIVE until both AW and the last W beat are done
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state    <= IDLE;
      gnt      <= 1'b0;
      rr_ptr   <= 1'b0;
      aw_done  <= 1'b0;
      w_done   <= 1'b0;
      aw_valid <= 1'b0;
      aw_addr  <= 32'd0;
      aw_len   <= 8'd0;
      aw_size  <= 3'd0;
      aw_burst <= 2'd0;
      aw_id    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_ok) begin
            gnt      <= sel;
            rr_ptr   <= ~sel;
            aw_done  <= 1'b0;
            w_done   <= 1'b0;
            aw_valid <= 1'b1;
            aw_addr  <= sel ? bus.S_AWADDR[63:32] : bus.S_AWADDR[31:0];
            aw_len   <= sel ? bus.S_AWLEN[15:8] : bus.S_AWLEN[7:0];
            aw_size  <= sel ? bus.S_AWSIZE[5:3] : bus.S_AWSIZE[2:0];
            aw_burst <= sel ? bus.S_AWBURST[3:2] : bus.S_AWBURST[1:0];
            aw_id    <= {sel, (sel ? bus.S_AWID[2*ID_W-1:ID_W] : bus.S_AWID[ID_W-1:0])};
            state    <= ACTIVE;
          end
        end
        default: begin
          if (aw_hs) begin
            aw_valid <= 1'b0;
            aw_done  <= 1'b1;
          end
          if (w_hs & w_last) w_done <= 1'b1;
          if ((aw_done | aw_hs) & (w_done | (w_hs & w_last))) state <= IDLE;
        end
      endcase
    end
  end

  // Writes in flight downstream: up on AW handshake, down on B handshake
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) outst_cnt <= 8'd0;
    else begin
      case ({aw_hs, b_hs})
        2'b10:   outst_cnt <= outst_cnt + 8'd1;
        2'b01:   outst_cnt <= outst_cnt - 8'd1;
        default: outst_cnt <= outst_cnt;
      endcase
    end
  end
endmodule

// File: tb/tb_axi_wr_arbiter.sv
// tb/tb_axi_wr_arbiter.sv - Randomized self-checking bench for axi_wr_arbiter against a transaction-level model
module tb_axi_wr_arbiter;
  localparam int MAXO = 2;

  logic aclk;
  logic areset;
  int   total = 0;
  int   bad   = 0;

  axi_wr_arbiter_if #(.ID_W(4), .DATA_LEN(32)) bus ();
  axi_wr_arbiter #(.ID_W(4), .DATA_LEN(32), .MAX_OUTST(MAXO)) dut (
    .ACLK(aclk), .ARESET(areset), .bus(bus)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  // Model: next tie winner, and downstream IDs awaiting a B response (oldest first)
  int         pref;
  logic [4:0] outq[$];
  logic       b_fire;

  logic [31:0] p_addr[2];
  logic [7:0]  p_len[2];
  logic [2:0]  p_size[2];
  logic [1:0]  p_burst[2];
  logic [3:0]  p_id[2];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic new_payload();
    for (int i = 0; i < 2; i++) begin
      p_addr[i]  = $urandom;
      p_len[i]   = 8'($urandom_range(0, 3));
      p_size[i]  = 3'($urandom_range(0, 2));
      p_burst[i] = 2'($urandom_range(0, 2));
      p_id[i]    = 4'($urandom_range(0, 15));
    end
  endtask

  task automatic put_aw(input logic [1:0] req);
    bus.S_AWVALID = req;
    bus.S_AWADDR  = {p_addr[1], p_addr[0]};
    bus.S_AWLEN   = {p_len[1], p_len[0]};
    bus.S_AWSIZE  = {p_size[1], p_size[0]};
    bus.S_AWBURST = {p_burst[1], p_burst[0]};
    bus.S_AWID    = {p_id[1], p_id[0]};
  endtask

  // Random B traffic; valid only for a write the model knows is outstanding
  task automatic drive_b();
    bus.M_BVALID = (outq.size() > 0) && ($urandom_range(0, 1) == 1);
    bus.M_BID    = bus.M_BVALID ? outq[0] : 5'($urandom);
    bus.M_BRESP  = 2'($urandom);
    bus.S_BREADY = 2'($urandom);
  endtask

  task automatic check_b();
    logic [1:0] exp_v;
    exp_v = bus.M_BVALID ? (bus.M_BID[4] ? 2'b10 : 2'b01) : 2'b00;
    check("s_bvalid", bus.S_BVALID, exp_v);
    check("m_bready", bus.M_BREADY, bus.S_BREADY[bus.M_BID[4]]);
    if (bus.M_BVALID) begin
      check("s_bid", bus.S_BID, bus.M_BID[3:0]);
      check("s_bresp", bus.S_BRESP, bus.M_BRESP);
    end
    b_fire = bus.M_BVALID && bus.S_BREADY[bus.M_BID[4]];
  endtask

  task automatic do_txn(input logic [1:0] req, input bit w_first);
    int         win, beats, bi;
    bit         granted, awd, wv, push;
    logic [1:0] exp_rdy;
    logic [31:0] d, junk;
    logic [3:0]  s, sj;
    win = (req == 2'b11) ? pref : ((req == 2'b10) ? 1 : 0);
    granted = 0;
    for (int t = 0; t < 60 && !granted; t++) begin
      @(negedge aclk);
      put_aw(req);
      bus.S_WVALID  = 2'($urandom);
      bus.M_WREADY  = 1'($urandom);
      bus.M_AWREADY = 1'($urandom);
      drive_b();
      #1;
      exp_rdy = (outq.size() < MAXO) ? (win == 1 ? 2'b10 : 2'b01) : 2'b00;
      check("s_awready_idle", bus.S_AWREADY, exp_rdy);
      check("m_awvalid_idle", bus.M_AWVALID, 0);
      check("m_wvalid_idle", bus.M_WVALID, 0);
      check("s_wready_idle", bus.S_WREADY, 0);
      check_b();
      @(posedge aclk);
      if (b_fire) void'(outq.pop_front());
      if (exp_rdy != 2'b00) granted = 1;
    end
    if (!granted) check("aw_grant_timeout", 0, 1);
    pref  = 1 - win;
    beats = int'(p_len[win]) + 1;
    bi    = 0;
    awd   = 0;
    for (int c = 0; c < 300 && !(awd && bi == beats); c++) begin
      @(negedge aclk);
      bus.S_AWVALID = 2'($urandom);
      bus.M_AWREADY = (w_first && bi < beats) ? 1'b0 : 1'($urandom);
      wv   = (bi < beats) && ($urandom_range(0, 1) == 1);
      d    = $urandom; junk = $urandom;
      s    = 4'($urandom); sj = 4'($urandom);
      bus.S_WVALID = (win == 1) ? {wv, 1'($urandom)} : {1'($urandom), wv};
      bus.S_WDATA  = (win == 1) ? {d, junk} : {junk, d};
      bus.S_WSTRB  = (win == 1) ? {s, sj} : {sj, s};
      bus.S_WLAST  = (win == 1) ? {(bi == beats - 1), 1'($urandom)} : {1'($urandom), (bi == beats - 1)};
      bus.M_WREADY = 1'($urandom);
      drive_b();
      #1;
      check("m_awvalid", bus.M_AWVALID, !awd);
      if (!awd) begin
        check("m_awaddr", bus.M_AWADDR, p_addr[win]);
        check("m_awlen", bus.M_AWLEN, p_len[win]);
        check("m_awsize", bus.M_AWSIZE, p_size[win]);
        check("m_awburst", bus.M_AWBURST, p_burst[win]);
        check("m_awid", bus.M_AWID, {win[0], p_id[win]});
      end
      check("s_awready_busy", bus.S_AWREADY, 0);
      check("m_wvalid", bus.M_WVALID, wv);
      check("s_wready", bus.S_WREADY, (bi < beats && bus.M_WREADY) ? (win == 1 ? 2'b10 : 2'b01) : 2'b00);
      if (wv) begin
        check("m_wdata", bus.M_WDATA, d);
        check("m_wstrb", bus.M_WSTRB, s);
        check("m_wlast", bus.M_WLAST, (bi == beats - 1));
      end
      check_b();
      push = !awd && bus.M_AWREADY;
      @(posedge aclk);
      if (b_fire) void'(outq.pop_front());
      if (push) begin
        awd = 1;
        outq.push_back({win[0], p_id[win]});
      end
      if (wv && bus.M_WREADY) bi++;
    end
    if (!(awd && bi == beats)) check("burst_timeout", 0, 1);
  endtask

  initial begin
    areset = 1'b1;
    pref   = 0;
    new_payload();
    put_aw(2'b11);
    bus.S_WVALID = 2'b11; bus.S_WLAST = 2'b00; bus.S_WDATA = '0; bus.S_WSTRB = '0;
    bus.M_AWREADY = 1'b1; bus.M_WREADY = 1'b1;
    bus.M_BVALID = 1'b1; bus.M_BID = 5'h13; bus.M_BRESP = 2'b00; bus.S_BREADY = 2'b11;
    #12;
    check("rst_s_awready", bus.S_AWREADY, 0);
    check("rst_m_awvalid", bus.M_AWVALID, 0);
    check("rst_m_wvalid", bus.M_WVALID, 0);
    check("rst_s_wready", bus.S_WREADY, 0);
    check("rst_m_bready", bus.M_BREADY, 0);
    check("rst_s_bvalid", bus.S_BVALID, 0);
    @(negedge aclk);
    areset = 1'b0;
    bus.S_AWVALID = 2'b00; bus.S_WVALID = 2'b00; bus.M_BVALID = 1'b0; bus.S_BREADY = 2'b00;

    // Directed B routing, no handshake crosses a clock edge
    @(negedge aclk);
    bus.M_BVALID = 1'b1; bus.M_BID = 5'h13; bus.M_BRESP = 2'b10; bus.S_BREADY = 2'b01;
    #1;
    check("b_dir_svalid", bus.S_BVALID, 2'b10);
    check("b_dir_sbid", bus.S_BID, 4'h3);
    check("b_dir_sbresp", bus.S_BRESP, 2'b10);
    check("b_dir_bready0", bus.M_BREADY, 0);
    bus.S_BREADY = 2'b10;
    #1;
    check("b_dir_bready1", bus.M_BREADY, 1);
    bus.M_BVALID = 1'b0; bus.S_BREADY = 2'b00;

    // Single master burst
    new_payload();
    p_addr[0] = 32'h1000; p_len[0] = 8'd3; p_id[0] = 4'd2;
    do_txn(2'b01, 0);
    // Contention alternates, outstanding limit throttles grants
    for (int k = 0; k < 4; k++) begin
      new_payload();
      p_len[0] = 8'd0; p_len[1] = 8'd0;
      do_txn(2'b11, 0);
    end
    // W completes before AW
    new_payload();
    p_len[1] = 8'd0;
    do_txn(2'b10, 1);
    // Random traffic
    for (int k = 0; k < 40; k++) begin
      new_payload();
      do_txn(2'($urandom_range(1, 3)), ($urandom_range(0, 3) == 0));
    end

    // Drain outstanding writes, then reset in the middle of a 4-beat burst
    for (int t = 0; t < 50 && outq.size() > 0; t++) begin
      @(negedge aclk);
      bus.S_AWVALID = 2'b00; bus.S_WVALID = 2'b00;
      bus.M_BVALID = 1'b1; bus.M_BID = outq[0]; bus.S_BREADY = 2'b11;
      #1;
      check("drain_bready", bus.M_BREADY, 1);
      @(posedge aclk);
      void'(outq.pop_front());
    end
    @(negedge aclk);
    bus.M_BVALID = 1'b0; bus.S_BREADY = 2'b00;
    new_payload();
    p_len[0] = 8'd3;
    put_aw(2'b01);
    #1;
    check("rst_test_grant", bus.S_AWREADY, 2'b01);
    @(negedge aclk);
    bus.S_AWVALID = 2'b00; bus.M_AWREADY = 1'b0;
    bus.S_WVALID = 2'b01; bus.S_WLAST = 2'b00; bus.M_WREADY = 1'b1;
    @(negedge aclk);
    #1;
    check("rst_test_beat2", bus.M_WVALID, 1);
    bus.S_AWVALID = 2'b11;
    bus.M_BVALID = 1'b1; bus.M_BID = 5'h10; bus.S_BREADY = 2'b11;
    areset = 1'b1;
    #1;
    check("mid_rst_m_awvalid", bus.M_AWVALID, 0);
    check("mid_rst_m_wvalid", bus.M_WVALID, 0);
    check("mid_rst_s_wready", bus.S_WREADY, 0);
    check("mid_rst_s_awready", bus.S_AWREADY, 0);
    check("mid_rst_m_bready", bus.M_BREADY, 0);
    check("mid_rst_s_bvalid", bus.S_BVALID, 0);
    @(negedge aclk);
    areset = 1'b0;
    bus.M_BVALID = 1'b0; bus.S_BREADY = 2'b00; bus.S_WVALID = 2'b00;
    bus.S_AWVALID = 2'b11;
    #1;
    check("post_rst_tie_m0", bus.S_AWREADY, 2'b01);
    check("post_rst_m_awvalid", bus.M_AWVALID, 0);
    @(posedge aclk);
    #1;
    check("post_rst_aw_latency", bus.M_AWVALID, 1);
    check("post_rst_awid", bus.M_AWID, {1'b0, p_id[0]});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL global_timeout got=%0d exp=%0d", 1, 0);
    $fatal(1, "time limit");
  end
endmodule
